// File: rtl/hazard_control_unit_pkg.sv
// Shared encodings for the hazard control unit: forwarding selects and
// the sys handshake FSM states.
package hazard_control_unit_pkg;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_MEMWB   = 2'b01;
  localparam logic [1:0] FWD_EXMEM   = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_REQ    = 2'b01,
    S_ACKLOW = 2'b10,
    S_DONE   = 2'b11
  } sys_state_t;

endpackage

// File: rtl/hazard_control_unit_forwarding_unit.sv
// EX-stage operand forwarding selects. Purely combinational; the younger
// producer in EX/MEM wins over the older one in MEM/WB, and x0 never forwards.
module forwarding_unit
  import hazard_control_unit_pkg::*;
(
  input  logic [4:0] ID_EX_Rs1,
  input  logic [4:0] ID_EX_Rs2,
  input  logic [4:0] EX_MEM_Rd,
  input  logic       EX_MEM_reg_write,
  input  logic [4:0] MEM_WB_Rd,
  input  logic       MEM_WB_reg_write,
  output logic [1:0] forward_a,
  output logic [1:0] forward_b
);

  function automatic logic [1:0] select_source(input logic [4:0] rs,
                                               input logic [4:0] exmem_rd,
                                               input logic       exmem_we,
                                               input logic [4:0] memwb_rd,
                                               input logic       memwb_we);
    logic [1:0] sel;
    sel = FWD_REGFILE;
    if (exmem_we && (exmem_rd != 5'd0) && (exmem_rd == rs))
      sel = FWD_EXMEM;
    else if (memwb_we && (memwb_rd != 5'd0) && (memwb_rd == rs))
      sel = FWD_MEMWB;
    return sel;
  endfunction

  // Operand A and B selects from the two in-flight producers.
  always_comb begin
    forward_a = select_source(ID_EX_Rs1, EX_MEM_Rd, EX_MEM_reg_write,
                              MEM_WB_Rd, MEM_WB_reg_write);
    forward_b = select_source(ID_EX_Rs2, EX_MEM_Rd, EX_MEM_reg_write,
                              MEM_WB_Rd, MEM_WB_reg_write);
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use stall, branch flush, forwarding,
// whole-pipeline freeze around the sys I/O handshake, and a saturating
// stall/freeze cycle counter for performance debug.
module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter int SYS_TIMEOUT = 1000,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       IF_ID_Rs1,
  input  logic [4:0]       IF_ID_Rs2,
  input  logic [4:0]       ID_EX_Rs1,
  input  logic [4:0]       ID_EX_Rs2,
  input  logic [4:0]       ID_EX_Rd,
  input  logic             ID_EX_mem_read,
  input  logic [4:0]       EX_MEM_Rd,
  input  logic             EX_MEM_reg_write,
  input  logic             EX_MEM_sys,
  input  logic             branch_taken,
  input  logic [4:0]       MEM_WB_Rd,
  input  logic             MEM_WB_reg_write,
  input  logic             sys_ack,
  output logic             stall,
  output logic             flush,
  output logic             freeze,
  output logic [1:0]       forward_a,
  output logic [1:0]       forward_b,
  output logic             sys_req,
  output logic             sys_timeout,
  output logic [CNT_W-1:0] stall_cnt
);

  // Last timeout-counter value before giving up; unused when SYS_TIMEOUT is 0.
  localparam logic [31:0] TMO_LAST = (SYS_TIMEOUT > 0) ? 32'(SYS_TIMEOUT - 1) : 32'd0;

  sys_state_t  state;
  logic [31:0] tmo_cnt;
  logic        load_use;

  forwarding_unit u_forwarding_unit (
    .ID_EX_Rs1        (ID_EX_Rs1),
    .ID_EX_Rs2        (ID_EX_Rs2),
    .EX_MEM_Rd        (EX_MEM_Rd),
    .EX_MEM_reg_write (EX_MEM_reg_write),
    .MEM_WB_Rd        (MEM_WB_Rd),
    .MEM_WB_reg_write (MEM_WB_reg_write),
    .forward_a        (forward_a),
    .forward_b        (forward_b)
  );

  // Hazard resolution with priority freeze > flush > stall. Freeze rises in the
  // same cycle sys reaches MEM so nothing advances before the request goes out;
  // S_DONE drops it for exactly one cycle to let the sys instruction retire.
  always_comb begin
    load_use = ID_EX_mem_read && (ID_EX_Rd != 5'd0) &&
               ((ID_EX_Rd == IF_ID_Rs1) || (ID_EX_Rd == IF_ID_Rs2));
    freeze   = ((state == S_IDLE) && EX_MEM_sys) ||
               (state == S_REQ) || (state == S_ACKLOW);
    flush    = branch_taken && !freeze;
    stall    = load_use && !flush && !freeze;
  end

  // sys handshake FSM with registered request, timeout counter and sticky timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      sys_req     <= 1'b0;
      sys_timeout <= 1'b0;
      tmo_cnt     <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (EX_MEM_sys) begin
            state   <= S_REQ;
            sys_req <= 1'b1;
            tmo_cnt <= 32'd0;
          end
        end
        S_REQ: begin
          if (sys_ack) begin
            state   <= S_ACKLOW;
            sys_req <= 1'b0;
          end else if ((SYS_TIMEOUT != 0) && (tmo_cnt == TMO_LAST)) begin
            state       <= S_DONE;
            sys_req     <= 1'b0;
            sys_timeout <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end
        S_ACKLOW: begin
          if (!sys_ack) state <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state   <= S_IDLE;
          sys_req <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of cycles the front end is held by stall or freeze.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if ((stall || freeze) && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: directed scenarios plus
// randomized traffic against a behavioural model of the handshake and hazards.
module tb_hazard_control_unit;

  localparam int TMO    = 8;
  localparam int CW     = 4;
  localparam int CNTMAX = 15;

  // Model handshake phases
  localparam int P_IDLE   = 0;
  localparam int P_WAIT   = 1;
  localparam int P_ACKLOW = 2;
  localparam int P_DONE   = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [4:0]    IF_ID_Rs1 = '0, IF_ID_Rs2 = '0, ID_EX_Rs1 = '0, ID_EX_Rs2 = '0;
  logic [4:0]    ID_EX_Rd = '0, EX_MEM_Rd = '0, MEM_WB_Rd = '0;
  logic          ID_EX_mem_read = 0, EX_MEM_reg_write = 0, EX_MEM_sys = 0;
  logic          branch_taken = 0, MEM_WB_reg_write = 0, sys_ack = 0;
  logic          stall, flush, freeze, sys_req, sys_timeout;
  logic [1:0]    forward_a, forward_b;
  logic [CW-1:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  int   m_phase = P_IDLE;
  int   m_wait  = 0;
  int   m_cnt   = 0;
  logic m_req   = 0;
  logic m_to    = 0;

  hazard_control_unit #(.SYS_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .IF_ID_Rs1(IF_ID_Rs1), .IF_ID_Rs2(IF_ID_Rs2),
    .ID_EX_Rs1(ID_EX_Rs1), .ID_EX_Rs2(ID_EX_Rs2), .ID_EX_Rd(ID_EX_Rd),
    .ID_EX_mem_read(ID_EX_mem_read),
    .EX_MEM_Rd(EX_MEM_Rd), .EX_MEM_reg_write(EX_MEM_reg_write),
    .EX_MEM_sys(EX_MEM_sys), .branch_taken(branch_taken),
    .MEM_WB_Rd(MEM_WB_Rd), .MEM_WB_reg_write(MEM_WB_reg_write),
    .sys_ack(sys_ack),
    .stall(stall), .flush(flush), .freeze(freeze),
    .forward_a(forward_a), .forward_b(forward_b),
    .sys_req(sys_req), .sys_timeout(sys_timeout), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
    if (EX_MEM_reg_write && EX_MEM_Rd != 0 && EX_MEM_Rd == rs) return 2'b10;
    if (MEM_WB_reg_write && MEM_WB_Rd != 0 && MEM_WB_Rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic exp_freeze();
    return (m_phase == P_IDLE && EX_MEM_sys) || m_phase == P_WAIT || m_phase == P_ACKLOW;
  endfunction

  function automatic logic exp_flush();
    return branch_taken && !exp_freeze();
  endfunction

  function automatic logic exp_stall();
    logic hit;
    hit = ID_EX_mem_read && ID_EX_Rd != 0 && (ID_EX_Rd == IF_ID_Rs1 || ID_EX_Rd == IF_ID_Rs2);
    return hit && !exp_flush() && !exp_freeze();
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE; m_wait = 0; m_cnt = 0; m_req = 0; m_to = 0;
  endtask

  // Advance one clock: compute the model's next values from the pre-edge inputs.
  task automatic tick();
    int   nphase, nwait, ncnt;
    logic nreq, nto;
    nphase = m_phase; nwait = m_wait; ncnt = m_cnt; nreq = m_req; nto = m_to;
    if ((exp_stall() || exp_freeze()) && m_cnt < CNTMAX) ncnt = m_cnt + 1;
    case (m_phase)
      P_IDLE:   if (EX_MEM_sys) begin nphase = P_WAIT; nreq = 1; nwait = 0; end
      P_WAIT: begin
        if (sys_ack) begin nphase = P_ACKLOW; nreq = 0; end
        else if (m_wait + 1 == TMO) begin nphase = P_DONE; nreq = 0; nto = 1; end
        else nwait = m_wait + 1;
      end
      P_ACKLOW: if (!sys_ack) nphase = P_DONE;
      default:  nphase = P_IDLE;
    endcase
    @(posedge clk);
    if (!rst) begin
      m_phase = nphase; m_wait = nwait; m_cnt = ncnt; m_req = nreq; m_to = nto;
    end
    #1;
  endtask

  task automatic clear_inputs();
    IF_ID_Rs1 = 0; IF_ID_Rs2 = 0; ID_EX_Rs1 = 0; ID_EX_Rs2 = 0; ID_EX_Rd = 0;
    EX_MEM_Rd = 0; MEM_WB_Rd = 0; ID_EX_mem_read = 0; EX_MEM_reg_write = 0;
    EX_MEM_sys = 0; branch_taken = 0; MEM_WB_reg_write = 0; sys_ack = 0;
  endtask

  // Called at posedge+1; leaves time at the following posedge+1.
  task automatic do_reset();
    clear_inputs();
    rst = 1; #2; rst = 0;
    model_reset();
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    EX_MEM_sys = 1;
    #2;
    n_checks++; if (sys_req !== 1'b0) begin n_fail++; $display("FAIL reset_sys_req: got %b expected 0", sys_req); end
    n_checks++; if (sys_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_sys_timeout: got %b expected 0", sys_timeout); end
    n_checks++; if (stall_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
    n_checks++; if (freeze !== 1'b1) begin n_fail++; $display("FAIL reset_freeze_follows_sys: got %b expected 1", freeze); end
    EX_MEM_sys = 0;
    #1;
    n_checks++; if (freeze !== 1'b0) begin n_fail++; $display("FAIL reset_freeze_idle: got %b expected 0", freeze); end
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    tick();
  endtask

  task automatic test_forwarding();
    EX_MEM_Rd = 5; EX_MEM_reg_write = 1; MEM_WB_Rd = 5; MEM_WB_reg_write = 1; ID_EX_Rs1 = 5;
    #1;
    n_checks++; if (forward_a !== 2'b10) begin n_fail++; $display("FAIL fwd_exmem_priority: got %b expected 10", forward_a); end
    EX_MEM_reg_write = 0; #1;
    n_checks++; if (forward_a !== 2'b01) begin n_fail++; $display("FAIL fwd_memwb: got %b expected 01", forward_a); end
    EX_MEM_reg_write = 1; EX_MEM_Rd = 0; MEM_WB_Rd = 0; ID_EX_Rs1 = 0; #1;
    n_checks++; if (forward_a !== 2'b00) begin n_fail++; $display("FAIL fwd_x0: got %b expected 00", forward_a); end
    EX_MEM_Rd = 9; MEM_WB_Rd = 4; ID_EX_Rs2 = 4; #1;
    n_checks++; if (forward_b !== 2'b01) begin n_fail++; $display("FAIL fwd_b_memwb: got %b expected 01", forward_b); end
    for (int i = 0; i < 60; i++) begin
      ID_EX_Rs1 = 5'($urandom_range(0, 3)); ID_EX_Rs2 = 5'($urandom_range(0, 3));
      EX_MEM_Rd = 5'($urandom_range(0, 3)); MEM_WB_Rd = 5'($urandom_range(0, 3));
      EX_MEM_reg_write = 1'($urandom); MEM_WB_reg_write = 1'($urandom);
      #1;
      n_checks++; if (forward_a !== exp_fwd(ID_EX_Rs1)) begin n_fail++; $display("FAIL fwd_a_rand: got %b expected %b", forward_a, exp_fwd(ID_EX_Rs1)); end
      n_checks++; if (forward_b !== exp_fwd(ID_EX_Rs2)) begin n_fail++; $display("FAIL fwd_b_rand: got %b expected %b", forward_b, exp_fwd(ID_EX_Rs2)); end
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    ID_EX_mem_read = 1; ID_EX_Rd = 7; IF_ID_Rs2 = 7; IF_ID_Rs1 = 3; #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall: got %b expected 1", stall); end
    branch_taken = 1; #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_branch_stall: got %b expected 0", stall); end
    n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL lu_branch_flush: got %b expected 1", flush); end
    branch_taken = 0; ID_EX_Rd = 0; IF_ID_Rs2 = 0; #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_x0: got %b expected 0", stall); end
    tick();
    for (int i = 0; i < 50; i++) begin
      ID_EX_mem_read = 1'($urandom); ID_EX_Rd = 5'($urandom_range(0, 3));
      IF_ID_Rs1 = 5'($urandom_range(0, 3)); IF_ID_Rs2 = 5'($urandom_range(0, 3));
      branch_taken = ($urandom_range(0, 3) == 0);
      #1;
      n_checks++; if (stall !== exp_stall()) begin n_fail++; $display("FAIL lu_rand_stall: got %b expected %b", stall, exp_stall()); end
      n_checks++; if (flush !== exp_flush()) begin n_fail++; $display("FAIL lu_rand_flush: got %b expected %b", flush, exp_flush()); end
      n_checks++; if (stall_cnt !== 4'(m_cnt)) begin n_fail++; $display("FAIL lu_rand_cnt: got %0d expected %0d", stall_cnt, m_cnt); end
      tick();
    end
    clear_inputs();
  endtask

  // Full handshake with a branch held in EX/MEM during the freeze.
  task automatic test_sys_handshake();
    do_reset();
    EX_MEM_sys = 1; branch_taken = 1; #1;                               // t
    n_checks++; if (freeze !== 1'b1) begin n_fail++; $display("FAIL hs_freeze_t: got %b expected 1", freeze); end
    n_checks++; if (sys_req !== 1'b0) begin n_fail++; $display("FAIL hs_req_t: got %b expected 0", sys_req); end
    n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL hs_flush_frozen: got %b expected 0", flush); end
    tick();                                                              // t+1
    n_checks++; if (sys_req !== 1'b1) begin n_fail++; $display("FAIL hs_req_t1: got %b expected 1", sys_req); end
    tick(); tick();                                                      // t+3
    tick(); sys_ack = 1; #1;                                             // t+4
    n_checks++; if (sys_req !== 1'b1) begin n_fail++; $display("FAIL hs_req_t4: got %b expected 1", sys_req); end
    tick();                                                              // t+5
    n_checks++; if (sys_req !== 1'b0) begin n_fail++; $display("FAIL hs_req_t5: got %b expected 0", sys_req); end
    n_checks++; if (freeze !== 1'b1) begin n_fail++; $display("FAIL hs_freeze_t5: got %b expected 1", freeze); end
    tick(); sys_ack = 0; #1;                                             // t+6
    n_checks++; if (freeze !== 1'b1) begin n_fail++; $display("FAIL hs_freeze_t6: got %b expected 1", freeze); end
    tick();                                                              // t+7 done
    n_checks++; if (freeze !== 1'b0) begin n_fail++; $display("FAIL hs_freeze_done: got %b expected 0", freeze); end
    n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL hs_flush_done: got %b expected 1", flush); end
    tick();                                                              // t+8
    EX_MEM_sys = 0; branch_taken = 0; #1;
    n_checks++; if (sys_req !== 1'b0) begin n_fail++; $display("FAIL hs_no_retrigger: got %b expected 0", sys_req); end
    n_checks++; if (freeze !== 1'b0) begin n_fail++; $display("FAIL hs_idle_freeze: got %b expected 0", freeze); end
    n_checks++; if (stall_cnt !== 4'(m_cnt)) begin n_fail++; $display("FAIL hs_cnt: got %0d expected %0d", stall_cnt, m_cnt); end
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    EX_MEM_sys = 1; sys_ack = 0; #1;
    tick();                                                              // first S_REQ cycle
    for (int i = 1; i < TMO; i++) tick();                                // 8th S_REQ cycle
    n_checks++; if (sys_timeout !== 1'b0) begin n_fail++; $display("FAIL to_early: got %b expected 0", sys_timeout); end
    n_checks++; if (freeze !== 1'b1) begin n_fail++; $display("FAIL to_freeze_wait: got %b expected 1", freeze); end
    tick();
    n_checks++; if (sys_timeout !== 1'b1) begin n_fail++; $display("FAIL to_set: got %b expected 1", sys_timeout); end
    n_checks++; if (freeze !== 1'b0) begin n_fail++; $display("FAIL to_freeze_drop: got %b expected 0", freeze); end
    n_checks++; if (sys_req !== 1'b0) begin n_fail++; $display("FAIL to_req: got %b expected 0", sys_req); end
    tick(); EX_MEM_sys = 0;
    for (int i = 0; i < 5; i++) tick();
    n_checks++; if (sys_timeout !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %b expected 1", sys_timeout); end
  endtask

  // Continues from test_timeout with sys_timeout still set.
  task automatic test_reset_mid_handshake();
    EX_MEM_sys = 1; #1;
    tick(); tick(); tick();
    n_checks++; if (sys_req !== 1'b1) begin n_fail++; $display("FAIL rm_req_before: got %b expected 1", sys_req); end
    rst = 1; EX_MEM_sys = 0; #1;
    n_checks++; if (sys_req !== 1'b0) begin n_fail++; $display("FAIL rm_req: got %b expected 0", sys_req); end
    n_checks++; if (freeze !== 1'b0) begin n_fail++; $display("FAIL rm_freeze: got %b expected 0", freeze); end
    n_checks++; if (stall_cnt !== 4'd0) begin n_fail++; $display("FAIL rm_cnt: got %0d expected 0", stall_cnt); end
    n_checks++; if (sys_timeout !== 1'b0) begin n_fail++; $display("FAIL rm_timeout: got %b expected 0", sys_timeout); end
    #1; rst = 0;
    model_reset();
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    ID_EX_mem_read = 1; ID_EX_Rd = 7; IF_ID_Rs2 = 7; #1;
    for (int i = 0; i < 5; i++) tick();
    n_checks++; if (stall_cnt !== 4'd5) begin n_fail++; $display("FAIL sat_mid: got %0d expected 5", stall_cnt); end
    for (int i = 0; i < 15; i++) tick();
    n_checks++; if (stall_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_hold: got %0d expected 15", stall_cnt); end
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL sat_stall: got %b expected 1", stall); end
    clear_inputs();
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      IF_ID_Rs1 = 5'($urandom_range(0, 3)); IF_ID_Rs2 = 5'($urandom_range(0, 3));
      ID_EX_Rs1 = 5'($urandom_range(0, 3)); ID_EX_Rs2 = 5'($urandom_range(0, 3));
      ID_EX_Rd = 5'($urandom_range(0, 3)); EX_MEM_Rd = 5'($urandom_range(0, 3));
      MEM_WB_Rd = 5'($urandom_range(0, 3));
      ID_EX_mem_read = 1'($urandom); EX_MEM_reg_write = 1'($urandom);
      MEM_WB_reg_write = 1'($urandom);
      EX_MEM_sys = ($urandom_range(0, 5) == 0);
      branch_taken = ($urandom_range(0, 4) == 0);
      sys_ack = ($urandom_range(0, 3) == 0);
      #1;
      n_checks++; if (freeze !== exp_freeze()) begin n_fail++; $display("FAIL rnd_freeze: got %b expected %b", freeze, exp_freeze()); end
      n_checks++; if (flush !== exp_flush()) begin n_fail++; $display("FAIL rnd_flush: got %b expected %b", flush, exp_flush()); end
      n_checks++; if (stall !== exp_stall()) begin n_fail++; $display("FAIL rnd_stall: got %b expected %b", stall, exp_stall()); end
      n_checks++; if (sys_req !== m_req) begin n_fail++; $display("FAIL rnd_req: got %b expected %b", sys_req, m_req); end
      n_checks++; if (sys_timeout !== m_to) begin n_fail++; $display("FAIL rnd_timeout: got %b expected %b", sys_timeout, m_to); end
      n_checks++; if (stall_cnt !== 4'(m_cnt)) begin n_fail++; $display("FAIL rnd_cnt: got %0d expected %0d", stall_cnt, m_cnt); end
      n_checks++; if (forward_a !== exp_fwd(ID_EX_Rs1)) begin n_fail++; $display("FAIL rnd_fwd_a: got %b expected %b", forward_a, exp_fwd(ID_EX_Rs1)); end
      n_checks++; if (forward_b !== exp_fwd(ID_EX_Rs2)) begin n_fail++; $display("FAIL rnd_fwd_b: got %b expected %b", forward_b, exp_fwd(ID_EX_Rs2)); end
      tick();
      if ((i % 100) == 99) do_reset();
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_sys_handshake();
    test_timeout();
    test_reset_mid_handshake();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
